// File: rtl/riscv_pkg.sv
// Shared RV32I opcode constants, instruction format decode and encoder payload types.
// Used by the instruction packer and by any immediate decoder that needs the same format map.
package riscv_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned OPC_W     = 7;
    localparam int unsigned REG_W     = 5;
    localparam int unsigned F3_W      = 3;
    localparam int unsigned F7_W      = 7;
    localparam int unsigned ERR_CNT_W = 8;

    localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
    localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
    localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
    localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
    localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;

    localparam logic [XLEN-1:0] NOP_WORD = 32'h0000_0013;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J,
        FMT_ILLEGAL
    } fmt_e;

    typedef struct packed {
        logic [OPC_W-1:0] opcode;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [F3_W-1:0]  funct3;
        logic [F7_W-1:0]  funct7;
        logic [XLEN-1:0]  imm;
    } fields_t;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic            err;
    } enc_t;

    function automatic fmt_e decode_fmt(input logic [OPC_W-1:0] opc);
        fmt_e fmt;
        fmt = FMT_ILLEGAL;
        case (opc)
            OPC_OP:                          fmt = FMT_R;
            OPC_LOAD, OPC_OP_IMM, OPC_JALR:  fmt = FMT_I;
            OPC_STORE:                       fmt = FMT_S;
            OPC_BRANCH:                      fmt = FMT_B;
            OPC_LUI, OPC_AUIPC:              fmt = FMT_U;
            OPC_JAL:                         fmt = FMT_J;
            default:                         fmt = FMT_ILLEGAL;
        endcase
        return fmt;
    endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational RV32I field packer; unknown opcodes become a NOP tagged with err.
// Optional immediate range check enabled by defining IMM_RANGE_CHECK_EN.
module instr_pack
    import riscv_pkg::*;
(
    input  fields_t fields,
    output enc_t    enc_c
);

    fmt_e fmt;
    logic range_err;
    logic illegal;

    assign fmt = decode_fmt(fields.opcode);

    always_comb begin
        enc_c.instr = NOP_WORD;
        illegal     = 1'b0;
        case (fmt)
            FMT_R: enc_c.instr = {fields.funct7, fields.rs2, fields.rs1, fields.funct3,
                                  fields.rd, fields.opcode};
            FMT_I: enc_c.instr = {fields.imm[11:0], fields.rs1, fields.funct3,
                                  fields.rd, fields.opcode};
            FMT_S: enc_c.instr = {fields.imm[11:5], fields.rs2, fields.rs1, fields.funct3,
                                  fields.imm[4:0], fields.opcode};
            FMT_B: enc_c.instr = {fields.imm[12], fields.imm[10:5], fields.rs2, fields.rs1,
                                  fields.funct3, fields.imm[4:1], fields.imm[11], fields.opcode};
            FMT_U: enc_c.instr = {fields.imm[31:12], fields.rd, fields.opcode};
            FMT_J: enc_c.instr = {fields.imm[20], fields.imm[10:1], fields.imm[11],
                                  fields.imm[19:12], fields.rd, fields.opcode};
            default: begin
                enc_c.instr = NOP_WORD;
                illegal     = 1'b1;
            end
        endcase
        enc_c.err = illegal | range_err;
    end

`ifdef IMM_RANGE_CHECK_EN
    // Flag immediates that the format cannot represent; the word is still truncated.
    always_comb begin
        range_err = 1'b0;
        case (fmt)
            FMT_I, FMT_S: range_err = (fields.imm[31:11] != {21{fields.imm[11]}});
            FMT_B:        range_err = (fields.imm[31:12] != {20{fields.imm[12]}}) || fields.imm[0];
            FMT_J:        range_err = (fields.imm[31:20] != {12{fields.imm[20]}}) || fields.imm[0];
            FMT_U:        range_err = (fields.imm[11:0] != 12'd0);
            default:      range_err = 1'b0;
        endcase
    end
`else
    logic unused_imm_lsb;
    assign unused_imm_lsb = fields.imm[0];
    assign range_err      = 1'b0;
`endif

endmodule

// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs field sets, buffers results in a 2-entry FIFO, counts pushes/errors.
// Define IMM_RANGE_CHECK_EN to also flag out-of-range immediates.
module instr_encoder
    import riscv_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [OPC_W-1:0]     opcode_i,
    input  logic [REG_W-1:0]     rd_i,
    input  logic [REG_W-1:0]     rs1_i,
    input  logic [REG_W-1:0]     rs2_i,
    input  logic [F3_W-1:0]      funct3_i,
    input  logic [F7_W-1:0]      funct7_i,
    input  logic [XLEN-1:0]      imm_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [XLEN-1:0]      instr_o,
    output logic                 err_o,
    output logic [CNT_W-1:0]     acc_cnt_o,
    output logic [ERR_CNT_W-1:0] err_cnt_o
);

    fields_t fields;
    enc_t    enc_c;
    enc_t    tail_q;
    logic    tail_valid;
    logic    push;
    logic    pop;

    always_comb begin
        fields.opcode = opcode_i;
        fields.rd     = rd_i;
        fields.rs1    = rs1_i;
        fields.rs2    = rs2_i;
        fields.funct3 = funct3_i;
        fields.funct7 = funct7_i;
        fields.imm    = imm_i;
    end

    instr_pack u_pack (
        .fields (fields),
        .enc_c  (enc_c)
    );

    // Head entry lives directly in the output registers; a second entry only exists when the head does.
    assign in_ready_o = ~tail_valid;
    assign push       = in_valid_i & ~tail_valid;
    assign pop        = out_valid_o & out_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_o <= 1'b0;
            instr_o     <= '0;
            err_o       <= 1'b0;
            tail_valid  <= 1'b0;
            tail_q      <= '0;
        end else if (pop) begin
            if (tail_valid) begin
                instr_o    <= tail_q.instr;
                err_o      <= tail_q.err;
                tail_valid <= 1'b0;
            end else if (push) begin
                instr_o <= enc_c.instr;
                err_o   <= enc_c.err;
            end else begin
                out_valid_o <= 1'b0;
            end
        end else if (push) begin
            if (!out_valid_o) begin
                instr_o     <= enc_c.instr;
                err_o       <= enc_c.err;
                out_valid_o <= 1'b1;
            end else begin
                tail_q     <= enc_c;
                tail_valid <= 1'b1;
            end
        end
    end

    // Accepted count wraps; error count saturates.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_cnt_o <= '0;
            err_cnt_o <= '0;
        end else if (push) begin
            acc_cnt_o <= acc_cnt_o + CNT_W'(1);
            if (enc_c.err && (err_cnt_o != '1)) begin
                err_cnt_o <= err_cnt_o + ERR_CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: driver queues expected words, monitor checks on each pop.
// Range-check expectations follow the IMM_RANGE_CHECK_EN define.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [6:0]  opcode_i;
    logic [4:0]  rd_i, rs1_i, rs2_i;
    logic [2:0]  funct3_i;
    logic [6:0]  funct7_i;
    logic [31:0] imm_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] instr_o;
    logic        err_o;
    logic [15:0] acc_cnt_o;
    logic [7:0]  err_cnt_o;

    typedef struct packed {
        logic [31:0] instr;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   exp_acc = 0;
    int   exp_errc = 0;

`ifdef IMM_RANGE_CHECK_EN
    localparam logic RANGE_ERR = 1'b1;
`else
    localparam logic RANGE_ERR = 1'b0;
`endif

    instr_encoder #(.CNT_W(16)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .opcode_i    (opcode_i),
        .rd_i        (rd_i),
        .rs1_i       (rs1_i),
        .rs2_i       (rs2_i),
        .funct3_i    (funct3_i),
        .funct7_i    (funct7_i),
        .imm_i       (imm_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .instr_o     (instr_o),
        .err_o       (err_o),
        .acc_cnt_o   (acc_cnt_o),
        .err_cnt_o   (err_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    task automatic set_fields(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                              input logic [31:0] imm);
        opcode_i = op; rd_i = rd; rs1_i = rs1; rs2_i = rs2;
        funct3_i = f3; funct7_i = f7; imm_i = imm;
    endtask

    // Drive one field set until accepted; call just after a rising edge.
    task automatic send(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] imm, input logic [31:0] ei, input logic ee);
        int  n;
        exp_t e;
        n = 0;
        set_fields(op, rd, rs1, rs2, f3, f7, imm);
        in_valid_i = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready_o) begin
                e.instr = ei;
                e.err   = ee;
                sb.push_back(e);
                exp_acc++;
                if (ee && exp_errc < 255) exp_errc++;
                break;
            end
            n++;
            if (n > 50) begin
                checks++;
                errors++;
                $display("FAIL push_timeout: in_ready_o stuck at %0b, required 1", in_ready_o);
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        in_valid_i = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain", 32'(sb.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    // Monitor: compare every retired word against the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_i && out_valid_o && out_ready_i) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: got 0x%08h, expected no output", instr_o);
                end else begin
                    e = sb.pop_front();
                    check("instr_o", instr_o, e.instr);
                    check("err_o", 32'(err_o), 32'(e.err));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exceeded, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b1; in_valid_i = 1'b0; out_ready_i = 1'b0;
        set_fields(7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_i = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid_o), 32'd0);
        check("rst_in_ready", 32'(in_ready_o), 32'd1);
        check("rst_instr", instr_o, 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        check("rst_acc", 32'(acc_cnt_o), 32'd0);
        check("rst_errcnt", 32'(err_cnt_o), 32'd0);
        @(posedge clk); #1;

        // Latency 1 from empty
        out_ready_i = 1'b1;
        send(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h0050_0093, 1'b0);
        @(negedge clk);
        check("latency1_valid", 32'(out_valid_o), 32'd1);
        @(posedge clk); #1;

        // Streaming formats
        send(7'b0100011, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8,         32'h0020_A423, 1'b0);
        send(7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC, 32'hFE00_0EE3, 1'b0);
        send(7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048,      32'h0010_00EF, 1'b0);
        send(7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 32'h1234_52B7, 1'b0);
        send(7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'd0,        32'h0020_81B3, 1'b0);
        send(7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'd0,        32'h4020_81B3, 1'b0);
        check("stream_in_ready", 32'(in_ready_o), 32'd1);
        wait_drain();

        // Backpressure: two fit, third waits, order kept
        out_ready_i = 1'b0;
        send(7'b0100011, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8,         32'h0020_A423, 1'b0);
        send(7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC, 32'hFE00_0EE3, 1'b0);
        set_fields(7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
        in_valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("full_in_ready", 32'(in_ready_o), 32'd0);
            check("hold_instr", instr_o, 32'h0020_A423);
            @(posedge clk); #1;
        end
        out_ready_i = 1'b1;
        @(negedge clk);
        check("full_pop_in_ready", 32'(in_ready_o), 32'd0);
        @(posedge clk); #1;
        send(7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 32'h0010_00EF, 1'b0);
        wait_drain();
        check("acc_cnt_bp", 32'(acc_cnt_o), 32'(exp_acc));

        // Immediate out of I range
        send(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 32'h8000_0093, RANGE_ERR);
        wait_drain();
        check("err_cnt_range", 32'(err_cnt_o), 32'(exp_errc));

        // Illegal opcode, saturating error counter
        for (int i = 0; i < 300; i++) begin
            send(7'b1111111, 5'd1, 5'd2, 5'd3, 3'd1, 7'd1, 32'd7, 32'h0000_0013, 1'b1);
        end
        wait_drain();
        check("err_cnt_sat", 32'(err_cnt_o), 32'd255);
        check("acc_cnt_total", 32'(acc_cnt_o), 32'(exp_acc));

        // Reset with two buffered entries
        out_ready_i = 1'b0;
        send(7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'd0, 32'h0020_81B3, 1'b0);
        send(7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'd0, 32'h4020_81B3, 1'b0);
        set_fields(7'b1111111, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        in_valid_i = 1'b1;
        rst_i = 1'b1;
        @(posedge clk); #1;
        rst_i = 1'b0;
        in_valid_i = 1'b0;
        sb.delete();
        exp_acc = 0;
        exp_errc = 0;
        @(negedge clk);
        check("mid_rst_out_valid", 32'(out_valid_o), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready_o), 32'd1);
        check("mid_rst_acc", 32'(acc_cnt_o), 32'd0);
        check("mid_rst_errcnt", 32'(err_cnt_o), 32'd0);
        @(posedge clk); #1;
        out_ready_i = 1'b1;
        send(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h0050_0093, 1'b0);
        wait_drain();
        check("post_rst_acc", 32'(acc_cnt_o), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
